// File: rtl/prog_pattern_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Holds the default config, the length-field width and the thermometer encoder.
package prog_pattern_det_pkg;

  localparam int DEF_PAT_W = 5;
  localparam int DEF_CNT_W = 8;
  localparam logic [4:0] DEF_PATTERN_BITS = 5'b11010;
  localparam int DEF_LEN_VAL = 5;

  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // n ones in the low bits; callers truncate to their own width
  function automatic logic [31:0] therm(input int n);
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/prog_pattern_detector_if.sv
// Stimulus/config/result bundle of the pattern detector.
// The master side drives data, strobe and config; the slave side is the detector.
interface prog_pattern_detector_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
);
  logic             data;
  logic             trig;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic [PAT_W-1:0] progress;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             cfg_err;
  logic             on_led;

  modport master (
    output data, trig, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  progress, match, match_count, cfg_err, on_led
  );

  modport slave (
    input  data, trig, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output progress, match, match_count, cfg_err, on_led
  );
endinterface

// File: rtl/prefix_suffix_match.sv
// Longest k <= len where pattern[len-1:len-k] equals the newest k valid history bits.
// Purely combinational, no backpressure.
module prefix_suffix_match #(
  parameter int PAT_W = 5,
  parameter int LEN_W = 3
) (
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] history,
  input  logic [LEN_W-1:0] valid_cnt,
  output logic [LEN_W-1:0] prefix_len
);

  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;

  // history[0] is the newest bit and lines up with pattern[len-k]
  always_comb begin
    prefix_len = '0;
    cand       = '0;
    mask       = '0;
    for (int k = 1; k <= PAT_W; k++) begin
      if (k <= int'(len) && k <= int'(valid_cnt)) begin
        cand = pattern >> (int'(len) - k);
        mask = {PAT_W{1'b1}} >> (PAT_W - k);
        if (((cand ^ history) & mask) == '0)
          prefix_len = LEN_W'(k);
      end
    end
  end

endmodule

// File: rtl/prog_pattern_detector.sv
// Programmable serial pattern detector with thermometer progress and saturating match count.
// Outputs registered one cycle after the sampling edge; no backpressure, data consumed when trig=1.
module prog_pattern_detector
  import prog_pattern_det_pkg::*;
#(
  parameter int               PAT_W       = DEF_PAT_W,
  parameter int               CNT_W       = DEF_CNT_W,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEF_PATTERN_BITS),
  parameter int               DEF_LEN     = DEF_LEN_VAL,
  localparam int              LEN_W       = len_width(PAT_W)
) (
  input logic                   clk,
  input logic                   reset,
  prog_pattern_detector_if.slave bus
);

  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic             err_r;
  logic [PAT_W-1:0] hist_r;
  logic [PAT_W-1:0] hist_nx;
  logic [LEN_W-1:0] vcnt_r;
  logic [LEN_W-1:0] vcnt_nx;
  logic [LEN_W-1:0] p_nx;
  logic [PAT_W-1:0] prog_r;
  logic             match_r;
  logic [CNT_W-1:0] cnt_r;
  logic             led_r;
  logic             sample;
  logic             hit;
  logic             cfg_bad;

  assign hist_nx = {hist_r[PAT_W-2:0], bus.data};
  assign vcnt_nx = (int'(vcnt_r) >= PAT_W) ? vcnt_r : vcnt_r + 1'b1;
  assign sample  = bus.trig && !err_r && !bus.cfg_load;
  assign hit     = sample && (p_nx == len_r);
  assign cfg_bad = (bus.cfg_len == '0) || (int'(bus.cfg_len) > PAT_W);

  prefix_suffix_match #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_psm (
    .pattern    (pat_r),
    .len        (len_r),
    .history    (hist_nx),
    .valid_cnt  (vcnt_nx),
    .prefix_len (p_nx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_r   <= DEF_PATTERN;
      len_r   <= LEN_W'(DEF_LEN);
      ovl_r   <= 1'b0;
      err_r   <= 1'b0;
      hist_r  <= '0;
      vcnt_r  <= '0;
      prog_r  <= '0;
      match_r <= 1'b0;
      led_r   <= 1'b0;
    end else begin
      led_r   <= 1'b1;
      match_r <= 1'b0;
      if (bus.cfg_load) begin
        pat_r  <= bus.cfg_pattern;
        len_r  <= bus.cfg_len;
        ovl_r  <= bus.cfg_overlap;
        err_r  <= cfg_bad;
        hist_r <= '0;
        vcnt_r <= '0;
        prog_r <= '0;
      end else if (sample) begin
        hist_r  <= hist_nx;
        // without overlap a full match restarts from an empty history
        vcnt_r  <= (hit && !ovl_r) ? '0 : vcnt_nx;
        prog_r  <= PAT_W'(therm(int'(p_nx)));
        match_r <= hit;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (hit) begin
      if (bus.cnt_clr)
        cnt_r <= CNT_W'(1);
      else if (cnt_r != {CNT_W{1'b1}})
        cnt_r <= cnt_r + 1'b1;
    end else if (bus.cnt_clr) begin
      cnt_r <= '0;
    end
  end

  assign bus.progress    = prog_r;
  assign bus.match       = match_r;
  assign bus.match_count = cnt_r;
  assign bus.cfg_err     = err_r;
  assign bus.on_led      = led_r;

endmodule

// File: tb/tb_prog_pattern_detector.sv
// Scoreboard bench: driver pushes hand-computed expectations, negedge monitor pops and compares.
module tb_prog_pattern_detector;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_pattern_detector_if #(.PAT_W(5), .CNT_W(3)) bus ();

  prog_pattern_detector #(.PAT_W(5), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0] prog;
    logic       m;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic err_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("progress", 32'(bus.progress), 32'(mon_e.prog));
      chk("match", 32'(bus.match), 32'(mon_e.m));
      chk("match_count", 32'(bus.match_count), 32'(mon_e.cnt));
      chk("cfg_err", 32'(bus.cfg_err), 32'(mon_e.err));
      chk("on_led", 32'(bus.on_led), 32'd1);
    end
  end

  task automatic drive(input logic d, input logic t, input logic ld, input logic clr,
                       input logic [4:0] pat, input logic [2:0] len, input logic ovl,
                       input logic [4:0] ep, input logic em, input logic [2:0] ec,
                       input logic ee);
    exp_t e;
    @(negedge clk);
    #1;
    bus.data        = d;
    bus.trig        = t;
    bus.cfg_load    = ld;
    bus.cnt_clr     = clr;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    e.prog = ep; e.m = em; e.cnt = ec; e.err = ee;
    q.push_back(e);
  endtask

  task automatic bitx(input logic d, input logic [4:0] ep, input logic em, input logic [2:0] ec);
    drive(d, 1'b1, 1'b0, 1'b0, 5'b0, 3'd0, 1'b0, ep, em, ec, err_exp);
  endtask

  task automatic hold(input logic d, input logic [4:0] ep, input logic [2:0] ec);
    drive(d, 1'b0, 1'b0, 1'b0, 5'b0, 3'd0, 1'b0, ep, 1'b0, ec, err_exp);
  endtask

  // trig held high during the load so that data bit must be discarded
  task automatic load(input logic [4:0] pat, input logic [2:0] len, input logic ovl,
                      input logic ee, input logic [2:0] ec);
    err_exp = ee;
    drive(1'b1, 1'b1, 1'b1, 1'b0, pat, len, ovl, 5'b0, 1'b0, ec, ee);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_progress"}, 32'(bus.progress), 32'd0);
    chk({tag, "_match"}, 32'(bus.match), 32'd0);
    chk({tag, "_count"}, 32'(bus.match_count), 32'd0);
    chk({tag, "_cfg_err"}, 32'(bus.cfg_err), 32'd0);
    chk({tag, "_on_led"}, 32'(bus.on_led), 32'd0);
  endtask

  initial begin
    bus.data = 0; bus.trig = 0; bus.cfg_load = 0; bus.cnt_clr = 0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #2 chk_zero("reset");
    @(negedge clk);
    chk_zero("reset_held");
    #1 reset = 1'b0;

    // default 11010, no overlap
    bitx(1, 5'b00001, 0, 3'd0);
    bitx(1, 5'b00011, 0, 3'd0);
    bitx(0, 5'b00111, 0, 3'd0);
    bitx(1, 5'b01111, 0, 3'd0);
    bitx(0, 5'b11111, 1, 3'd1);
    bitx(1, 5'b00001, 0, 3'd1);

    // 1,1,1,0 falls back to prefix 11 then 110; trig low holds
    load(5'b11010, 3'd5, 0, 0, 3'd1);
    bitx(1, 5'b00001, 0, 3'd1);
    bitx(1, 5'b00011, 0, 3'd1);
    bitx(1, 5'b00011, 0, 3'd1);
    bitx(0, 5'b00111, 0, 3'd1);
    hold(1, 5'b00111, 3'd1);
    hold(0, 5'b00111, 3'd1);
    hold(1, 5'b00111, 3'd1);
    bitx(1, 5'b01111, 0, 3'd1);
    bitx(0, 5'b11111, 1, 3'd2);

    // 101 with overlap
    load(5'b00101, 3'd3, 1, 0, 3'd2);
    bitx(1, 5'b00001, 0, 3'd2);
    bitx(0, 5'b00011, 0, 3'd2);
    bitx(1, 5'b00111, 1, 3'd3);
    bitx(0, 5'b00011, 0, 3'd3);
    bitx(1, 5'b00111, 1, 3'd4);
    // 101 without overlap
    load(5'b00101, 3'd3, 0, 0, 3'd4);
    bitx(1, 5'b00001, 0, 3'd4);
    bitx(0, 5'b00011, 0, 3'd4);
    bitx(1, 5'b00111, 1, 3'd5);
    bitx(0, 5'b00000, 0, 3'd5);
    bitx(1, 5'b00001, 0, 3'd5);

    // invalid lengths 0 and 6
    load(5'b11010, 3'd0, 0, 1, 3'd5);
    for (int i = 0; i < 10; i++) bitx(((5'b11010 >> (4 - (i % 5))) & 5'd1) != 0, 5'b00000, 0, 3'd5);
    load(5'b11010, 3'd6, 0, 1, 3'd5);
    bitx(1, 5'b00000, 0, 3'd5);
    // upper pattern bits beyond len are ignored
    load(5'b10111, 3'd2, 0, 0, 3'd5);
    bitx(1, 5'b00001, 0, 3'd5);
    bitx(1, 5'b00011, 1, 3'd6);

    // saturation with 11, overlap
    load(5'b01011, 3'd2, 1, 0, 3'd6);
    drive(0, 0, 0, 1, 5'b0, 3'd0, 0, 5'b00000, 0, 3'd0, 0);
    bitx(1, 5'b00001, 0, 3'd0);
    for (int i = 2; i <= 12; i++) bitx(1, 5'b00011, 1, (i - 1 > 7) ? 3'd7 : 3'(i - 1));
    drive(1, 1, 0, 1, 5'b0, 3'd0, 0, 5'b00011, 1, 3'd1, 0);
    bitx(1, 5'b00011, 1, 3'd2);

    // async reset mid-sequence restores defaults
    load(5'b11010, 3'd5, 0, 0, 3'd2);
    bitx(1, 5'b00001, 0, 3'd2);
    bitx(1, 5'b00011, 0, 3'd2);
    bitx(0, 5'b00111, 0, 3'd2);
    @(negedge clk);
    #1 bus.trig = 1'b0;
    #1 reset = 1'b1;
    #1 chk_zero("midreset");
    @(negedge clk);
    chk_zero("midreset_held");
    #1 reset = 1'b0;
    bitx(1, 5'b00001, 0, 3'd0);
    bitx(1, 5'b00011, 0, 3'd0);
    bitx(0, 5'b00111, 0, 3'd0);
    bitx(1, 5'b01111, 0, 3'd0);
    bitx(0, 5'b11111, 1, 3'd1);
    hold(0, 5'b11111, 3'd1);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_pattern_detector.md
Name: prog_pattern_detector

Overview:
- Serial bit-pattern detector with a runtime-programmable pattern (1..PAT_W bits), overlapping or non-overlapping match modes, a thermometer progress display and a saturating match counter.
- Samples `data` only on cycles where `trig` is high.
- Intended to drive board LEDs and feed event counters in the board-level demo top.
- Generalised successor to the fixed 5-bit detector FSM.

Parameters:
- PAT_W, 5, maximum pattern length in bits (2..32).
- CNT_W, 8, match counter width.
- DEF_PATTERN, 5'b11010 (PAT_W bits), pattern loaded at reset.
- DEF_LEN, 5, pattern length loaded at reset.
- LEN_W, $clog2(PAT_W+1), width of length fields (derived; do not override).

Ports:
- clk, input, 1, clock.
- reset, input, 1, reset: asynchronous, active-high.
- data, input, 1, serial data bit.
- trig, input, 1, sample strobe: data consumed on cycles where trig=1.
- cfg_load, input, 1, latch cfg_* fields and restart detection.
- cfg_pattern, input, PAT_W, pattern; the first received bit is cfg_pattern[cfg_len-1], the last is bit 0.
- cfg_len, input, LEN_W, pattern length.
- cfg_overlap, input, 1, 1=overlapping matches allowed.
- cnt_clr, input, 1, clear match_count.
- progress, output, PAT_W, thermometer of matched-prefix length.
- match, output, 1, one-cycle pulse on complete match.
- match_count, output, CNT_W, saturating match count.
- cfg_err, output, 1, active configuration invalid.
- on_led, output, 1, alive indicator.

Behaviour:
- Reset values:
  - progress=0, match=0, match_count=0, cfg_err=0, on_led=0.
  - History cleared.
  - Active config = DEF_PATTERN / DEF_LEN / overlap=0.
- on_led: 1 from the first clk edge after reset release.
- Internal state:
  - Shift history of the last PAT_W sampled bits, plus a valid-bit count (0..PAT_W).
  - Registered prefix length P (0..len).
- Trig cycle, valid config, no cfg_load:
  - Shift data into the history.
  - Compute P = longest k ≤ len such that the top k pattern bits (pattern[len-1:len-k]) equal the newest k valid history bits.
  - Result is equivalent to a KMP automaton; e.g. pattern 11010 with history …111 gives P=2.
- Outputs registered, one-cycle latency from the sampling edge:
  - progress = (1<<P)-1.
  - match = (P==len).
- On match:
  - progress shows len ones for that cycle.
  - match pulses for exactly one cycle.
  - Overlap=1: history is retained, so the next bit can extend a proper suffix.
  - Overlap=0: history valid-count is cleared, so the next bit starts from empty.
- trig=0: state and progress held; match=0.
- cfg_load:
  - Latches pattern, len and overlap.
  - Clears history, P, progress and match.
  - Has priority over trig in the same cycle; that data bit is discarded.
  - match_count is unaffected.
- Invalid config:
  - cfg_len==0 or cfg_len>PAT_W sets cfg_err=1.
  - While cfg_err=1: trig ignored, progress=0, match never asserts.
  - Cleared only by loading a valid config.
- Pattern bits at positions ≥ len are ignored.
- progress bits at positions ≥ len are always 0.
- match_count:
  - Increments on each match.
  - Saturates at 2^CNT_W-1.
  - cnt_clr and match in the same cycle gives count=1.
  - cnt_clr alone gives 0.
- Reset asserted mid-sequence: immediate return to reset values, including the default config.

Decomposition:
- Header/package prog_pattern_det_pkg holds LEN_W derivation, default constants, and a thermometer-encode function.
- One combinational sub-module, prefix_suffix_match (pattern, len, history, valid count → P), instantiated once.
- The top holds config registers, history, counter and output registers.

Test Plan:
- Default config; trig=1 each cycle; data 1,1,0,1,0 → progress 00001, 00011, 00111, 01111, 11111; match pulses once, on the 5th output cycle; match_count=1; next bit 1 → progress 00001.
- Default config; data 1,1,1,0 → progress 00001, 00011, 00011, 00111; trig=0 for 3 cycles with toggling data → progress holds 00111, match=0.
- cfg_load pattern=3'b101, len=3, overlap=1; stream 1,0,1,0,1 → match on bits 3 and 5, count=2. Same stream with overlap=0 → single match on bit 3, then progress 00000, 00001.
- cfg_load with len=0 → cfg_err=1; 10 trig cycles of pattern data → progress=0, no match. Reload len=2, pattern=2'b11 → cfg_err=0; data 1,1 → match.
- CNT_W=3, pattern 2'b11, len 2, overlap=1; 12 consecutive 1s → 11 matches, count saturates at 7. Assert cnt_clr on a match cycle → count=1.
- Assert reset after data 1,1,0 (progress 00111) → all outputs 0 asynchronously, on_led=0. After release, default pattern 11010 detected again on 1,1,0,1,0.
